// File: rtl/button_gesture_decoder.sv
// Turns debounced press/release pulses into short, double and long press events,
// plus periodic auto-repeat ticks while a long press is held.
module button_gesture_decoder #(
   parameter int CNT_W      = 24,
   parameter int LONG_CNT   = 12000000,
   parameter int DBL_CNT    = 3000000,
   parameter int REPEAT_CNT = 2400000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_down,
   input  logic pb_up,
   output logic short_press,
   output logic double_press,
   output logic long_press,
   output logic repeat_tick,
   output logic busy
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] PRESSED   = 3'd1;
   localparam logic [2:0] WAIT2     = 3'd2;
   localparam logic [2:0] PRESS2    = 3'd3;
   localparam logic [2:0] LONG_HELD = 3'd4;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_CNT - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   logic             down;
   logic             up;
   logic             short_next;
   logic             double_next;
   logic             long_next;
   logic             repeat_next;

   // A press and release seen on the same edge cancel out.
   assign down = pb_down & ~pb_up;
   assign up   = pb_up & ~pb_down;

   assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
   assign busy    = (state != IDLE);

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      short_next  = 1'b0;
      double_next = 1'b0;
      long_next   = 1'b0;
      repeat_next = 1'b0;
      case (state)
         IDLE: begin
            if (down) begin
               state_next = PRESSED;
               cnt_next   = '0;
            end
         end
         PRESSED: begin
            if (up) begin
               state_next = WAIT2;
               cnt_next   = '0;
            end else if (cnt == LONG_LAST) begin
               state_next = LONG_HELD;
               cnt_next   = '0;
               long_next  = 1'b1;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         WAIT2: begin
            if (down) begin
               state_next = PRESS2;
               cnt_next   = '0;
            end else if (cnt == DBL_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
               short_next = 1'b1;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         // Untimed: a double press completes however long the second press is held.
         PRESS2: begin
            if (up) begin
               state_next  = IDLE;
               cnt_next    = '0;
               double_next = 1'b1;
            end
         end
         LONG_HELD: begin
            if (up) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == REPEAT_LAST) begin
               cnt_next    = '0;
               repeat_next = 1'b1;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         short_press  <= 1'b0;
         double_press <= 1'b0;
         long_press   <= 1'b0;
         repeat_tick  <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         short_press  <= short_next;
         double_press <= double_next;
         long_press   <= long_next;
         repeat_tick  <= repeat_next;
      end
   end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with small timing parameters.
// Expected vectors are {busy, short_press, double_press, long_press, repeat_tick}.
module tb_button_gesture_decoder;

   localparam int CNT_W      = 8;
   localparam int LONG_CNT   = 8;
   localparam int DBL_CNT    = 5;
   localparam int REPEAT_CNT = 3;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic pb_down = 1'b0;
   logic pb_up   = 1'b0;
   logic short_press;
   logic double_press;
   logic long_press;
   logic repeat_tick;
   logic busy;

   int checks = 0;
   int fails  = 0;

   button_gesture_decoder #(
      .CNT_W      (CNT_W),
      .LONG_CNT   (LONG_CNT),
      .DBL_CNT    (DBL_CNT),
      .REPEAT_CNT (REPEAT_CNT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pb_down      (pb_down),
      .pb_up        (pb_up),
      .short_press  (short_press),
      .double_press (double_press),
      .long_press   (long_press),
      .repeat_tick  (repeat_tick),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Drives one edge's worth of input; returns 1 time unit after that edge.
   task automatic apply_stimulus(input logic down, input logic up);
      pb_down = down;
      pb_up   = up;
      @(posedge clk);
      #1;
      pb_down = 1'b0;
      pb_up   = 1'b0;
   endtask

   task automatic check_output(input string tag, input logic [4:0] expected);
      logic [4:0] observed;
      observed = {busy, short_press, double_press, long_press, repeat_tick};
      checks++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   initial begin
      logic [4:0] exp_vec;

      #12;
      check_output("reset", 5'b00000);
      rst_n = 1'b1;
      apply_stimulus(1'b0, 1'b0);
      check_output("idle after reset", 5'b00000);

      // Short press: down e0, up e3, short after e8
      apply_stimulus(1'b1, 1'b0);
      check_output("t1 e0", 5'b10000);
      for (int e = 1; e <= 9; e++) begin
         apply_stimulus(1'b0, (e == 3));
         exp_vec = 5'b10000;
         if (e == 8) exp_vec = 5'b01000;
         if (e == 9) exp_vec = 5'b00000;
         check_output($sformatf("t1 e%0d", e), exp_vec);
      end

      // Double press: down e0, up e2, down e5, up e20
      apply_stimulus(1'b1, 1'b0);
      check_output("t2 e0", 5'b10000);
      for (int e = 1; e <= 21; e++) begin
         apply_stimulus((e == 5), (e == 2 || e == 20));
         exp_vec = 5'b10000;
         if (e == 20) exp_vec = 5'b00100;
         if (e == 21) exp_vec = 5'b00000;
         check_output($sformatf("t2 e%0d", e), exp_vec);
      end

      // Long press with repeats: down e0, up e16
      apply_stimulus(1'b1, 1'b0);
      check_output("t3 e0", 5'b10000);
      for (int e = 1; e <= 17; e++) begin
         apply_stimulus(1'b0, (e == 16));
         exp_vec = 5'b10000;
         if (e == 8) exp_vec = 5'b10010;
         if (e == 11 || e == 14) exp_vec = 5'b10001;
         if (e >= 16) exp_vec = 5'b00000;
         check_output($sformatf("t3 e%0d", e), exp_vec);
      end

      // Release on a repeat edge: down e0, up e17 suppresses the tick
      apply_stimulus(1'b1, 1'b0);
      check_output("t3b e0", 5'b10000);
      for (int e = 1; e <= 18; e++) begin
         apply_stimulus(1'b0, (e == 17));
         exp_vec = 5'b10000;
         if (e == 8) exp_vec = 5'b10010;
         if (e == 11 || e == 14) exp_vec = 5'b10001;
         if (e >= 17) exp_vec = 5'b00000;
         check_output($sformatf("t3b e%0d", e), exp_vec);
      end

      // Release one edge before the long threshold: down e0, up e7, short after e12
      apply_stimulus(1'b1, 1'b0);
      check_output("t4a e0", 5'b10000);
      for (int e = 1; e <= 13; e++) begin
         apply_stimulus(1'b0, (e == 7));
         exp_vec = 5'b10000;
         if (e == 12) exp_vec = 5'b01000;
         if (e == 13) exp_vec = 5'b00000;
         check_output($sformatf("t4a e%0d", e), exp_vec);
      end

      // Release exactly on the long threshold edge: up wins, short after e13
      apply_stimulus(1'b1, 1'b0);
      check_output("t4r e0", 5'b10000);
      for (int e = 1; e <= 14; e++) begin
         apply_stimulus(1'b0, (e == 8));
         exp_vec = 5'b10000;
         if (e == 13) exp_vec = 5'b01000;
         if (e == 14) exp_vec = 5'b00000;
         check_output($sformatf("t4r e%0d", e), exp_vec);
      end

      // Second press inside window: down e0, up e2, down e6, up e9
      apply_stimulus(1'b1, 1'b0);
      check_output("t4b e0", 5'b10000);
      for (int e = 1; e <= 10; e++) begin
         apply_stimulus((e == 6), (e == 2 || e == 9));
         exp_vec = 5'b10000;
         if (e == 9) exp_vec = 5'b00100;
         if (e == 10) exp_vec = 5'b00000;
         check_output($sformatf("t4b e%0d", e), exp_vec);
      end

      // Second press on the short-press decision edge: down e0, up e2, down e7, up e9
      apply_stimulus(1'b1, 1'b0);
      check_output("t4c e0", 5'b10000);
      for (int e = 1; e <= 10; e++) begin
         apply_stimulus((e == 7), (e == 2 || e == 9));
         exp_vec = 5'b10000;
         if (e == 9) exp_vec = 5'b00100;
         if (e == 10) exp_vec = 5'b00000;
         check_output($sformatf("t4c e%0d", e), exp_vec);
      end

      // Reset mid-gesture, release while in reset
      apply_stimulus(1'b1, 1'b0);
      check_output("t5 e0", 5'b10000);
      for (int e = 1; e <= 4; e++) begin
         apply_stimulus(1'b0, 1'b0);
         check_output($sformatf("t5 e%0d", e), 5'b10000);
      end
      rst_n = 1'b0;
      #1;
      check_output("t5 async reset", 5'b00000);
      apply_stimulus(1'b0, 1'b1);
      check_output("t5 e5 in reset", 5'b00000);
      apply_stimulus(1'b0, 1'b0);
      check_output("t5 e6 in reset", 5'b00000);
      rst_n = 1'b1;
      for (int e = 7; e <= 14; e++) begin
         apply_stimulus(1'b0, 1'b0);
         check_output($sformatf("t5 e%0d quiet", e), 5'b00000);
      end
      apply_stimulus(1'b1, 1'b0);
      check_output("t5 fresh e0", 5'b10000);
      for (int e = 1; e <= 8; e++) begin
         apply_stimulus(1'b0, (e == 2));
         exp_vec = 5'b10000;
         if (e == 7) exp_vec = 5'b01000;
         if (e == 8) exp_vec = 5'b00000;
         check_output($sformatf("t5 fresh e%0d", e), exp_vec);
      end

      // Simultaneous down/up in IDLE is ignored
      apply_stimulus(1'b1, 1'b1);
      check_output("t6 idle both", 5'b00000);
      apply_stimulus(1'b0, 1'b0);
      check_output("t6 idle after", 5'b00000);

      // Simultaneous down/up in PRESSED: stays pressed, then up e2, short after e7
      apply_stimulus(1'b1, 1'b0);
      check_output("t6 e0", 5'b10000);
      apply_stimulus(1'b1, 1'b1);
      check_output("t6 e1 both", 5'b10000);
      for (int e = 2; e <= 8; e++) begin
         apply_stimulus(1'b0, (e == 2));
         exp_vec = 5'b10000;
         if (e == 7) exp_vec = 5'b01000;
         if (e == 8) exp_vec = 5'b00000;
         check_output($sformatf("t6 e%0d", e), exp_vec);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/button_gesture_decoder.md
Name: button_gesture_decoder

Overview:
- Sits directly downstream of the push-button debouncer and consumes its one-cycle press and release pulses.
- Classifies each interaction as a short press, double press or long press, and emits auto-repeat ticks while a long press is held.
- All outputs are single-cycle, registered pulses synchronous to clk, suitable for driving menu/parameter logic.

Parameters:
CNT_W, 24, width of the internal cycle counter
LONG_CNT, 12000000, cycles a press must be held to qualify as a long press (2 to 2^CNT_W-1)
DBL_CNT, 3000000, cycles after a release during which a second press makes a double press (2 to 2^CNT_W-1)
REPEAT_CNT, 2400000, auto-repeat period in cycles while long-held (2 to 2^CNT_W-1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pb_down  input  1  one-cycle pulse from debouncer: button just pressed
pb_up  input  1  one-cycle pulse from debouncer: button just released
short_press  output  1  one-cycle pulse: single press and release, no follow-up press
double_press  output  1  one-cycle pulse: second release of a double press
long_press  output  1  one-cycle pulse: hold reached LONG_CNT
repeat_tick  output  1  one-cycle pulse every REPEAT_CNT cycles after long_press while held
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, cnt 0, all outputs 0; reset mid-gesture discards it silently.
- Event rules:
  - pb_down and pb_up sampled high on the same edge: treated as no event.
  - An event not listed for the current state is ignored.
- cnt is cleared on every state entry and increments by 1 each cycle in timed states; it never wraps.
- Outputs are registered: each pulse is high for exactly the one cycle following the decision edge.
- States and transitions:
  - IDLE: pb_down -> PRESSED.
  - PRESSED:
    - pb_up -> WAIT2.
    - else if cnt == LONG_CNT-1 -> LONG_HELD, long_press=1.
    - pb_up on that same edge wins (goes to WAIT2, no long_press).
  - WAIT2:
    - pb_down -> PRESS2.
    - else if cnt == DBL_CNT-1 -> IDLE, short_press=1.
    - pb_down on that same edge wins.
  - PRESS2: untimed; pb_up -> IDLE, double_press=1 regardless of hold duration.
  - LONG_HELD:
    - pb_up -> IDLE, no pulse.
    - else if cnt == REPEAT_CNT-1 -> repeat_tick=1, cnt cleared, stay.
    - pb_up on a repeat edge wins (no repeat_tick).
- Timing from pb_down sampled at edge E with no release: long_press high after edge E+LONG_CNT; repeat_tick after E+LONG_CNT+k*REPEAT_CNT, k>=1.
- Timing for release sampled at edge R with no further press: short_press high after edge R+DBL_CNT.
- busy is combinational from state, low only in IDLE.
- At most one of short_press/double_press/long_press/repeat_tick is high in any cycle.

Test Plan (LONG_CNT=8, DBL_CNT=5, REPEAT_CNT=3):
1. Short press: pb_down at edge 0, pb_up at edge 3, then idle -> short_press high only in cycle after edge 8; busy high edges 0..8, low after.
2. Double press: pb_down at 0, pb_up at 2, pb_down at 5, pb_up at 20 -> double_press pulse after edge 20; no short_press or long_press at any time.
3. Long press with repeat: pb_down at 0, pb_up at 16 -> long_press after edge 8, repeat_tick after edges 11 and 14, no pulse at 16; IDLE after 16.
4. Boundary races:
   - pb_down at 0, pb_up at 7 -> no long_press; short_press after edge 12.
   - Separately: pb_down at 0, pb_up at 2, pb_down at 6 -> second press accepted (PRESS2), no short_press.
5. Reset mid-gesture: pb_down at 0, rst_n low at edge 5 for 2 cycles, release during reset -> all outputs 0, busy 0; a fresh pb_down/pb_up afterwards yields a normal short_press.
6. Simultaneous pb_down and pb_up in IDLE and in PRESSED -> state unchanged, no output pulse.
